spi_master_core: RTL

//  Full-duplex SPI master shift engine. Sits directly downstream of the SPI register file.

---
 rtl/spi_master_core_pkg.sv | 23 ++
 rtl/spi_master_core_if.sv | 21 ++
 rtl/spi_master_core_clk_div.sv | 40 ++++
 rtl/spi_master_core.sv | 128 ++++++++++++
 4 files changed

// File: rtl/spi_master_core_pkg.sv
// rtl/spi_master_core_pkg.sv - shared FSM encoding, default timing and helpers for the SPI master core
package spi_master_core_pkg;

    localparam int W_DATA_DEF   = 32;
    localparam int CLK_DIV_DEF  = 4;
    localparam int CS_SETUP_DEF = 2;
    localparam int CS_HOLD_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// rtl/spi_master_core_if.sv - word handshake between the SPI register file and the shift engine
interface spi_master_core_if #(
    parameter int W_DATA = 32
) ();
    logic [W_DATA-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [W_DATA-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_master_core_clk_div.sv
// rtl/spi_master_core_clk_div.sv - sclk divider with one-cycle rise/fall strobes
module spi_master_core_clk_div #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic rise_en_o,
    output logic fall_en_o,
    output logic sclk_o
);
    localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;
    logic             tc;

    // Strobes fire in the cycle whose closing edge toggles sclk.
    assign tc        = en_i && (cnt_q == DIV_TC);
    assign rise_en_o = tc && !sclk_q;
    assign fall_en_o = tc && sclk_q;
    assign sclk_o    = sclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (tc) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else if (en_i) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - full-duplex SPI mode 0 master, MSB first, one word per transfer
module spi_master_core
    import spi_master_core_pkg::*;
#(
    parameter int W_DATA   = W_DATA_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    spi_master_core_if.slave bus,
    output logic             sclk_o,
    output logic             mosi_o,
    input  logic             miso_i,
    output logic             cs_n_o
);
    localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD)) + 1;
    localparam int BIT_W = $clog2(W_DATA) + 1;

    localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(W_DATA - 1);

    state_e            state_q;
    logic [W_DATA-1:0] shift_tx_q;
    logic [W_DATA-1:0] shift_rx_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              tx_ready_q;
    logic [W_DATA-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              rise_en;
    logic              fall_en;

    spi_master_core_clk_div #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_clk_div (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (state_q == ST_SHIFT),
        .clr_i     (state_q != ST_SHIFT),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en),
        .sclk_o    (sclk_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            shift_tx_q <= '0;
            shift_rx_q <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        shift_tx_q <= bus.tx_data;
                        shift_rx_q <= '0;
                        bit_cnt_q  <= '0;
                        cnt_q      <= '0;
                        cs_n_q     <= 1'b0;
                        mosi_q     <= bus.tx_data[W_DATA-1];
                        tx_ready_q <= 1'b0;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_TC) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (rise_en) begin
                        shift_rx_q <= {shift_rx_q[W_DATA-2:0], miso_i};
                    end
                    // The slave samples on the rising edge, so the next bit goes out on the falling one.
                    if (fall_en) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_HOLD;
                        end else begin
                            shift_tx_q <= {shift_tx_q[W_DATA-2:0], 1'b0};
                            mosi_q     <= shift_tx_q[W_DATA-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    cs_n_q     <= 1'b1;
                    rx_data_q  <= shift_rx_q;
                    rx_valid_q <= 1'b1;
                    tx_ready_q <= 1'b1;
                    mosi_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = ~tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign mosi_o       = mosi_q;
    assign cs_n_o       = cs_n_q;
endmodule
